// File: rtl/pedal_spi_pkg.sv
// Shared definitions for the pedal's SPI codec link (initiator and responder).
package pedal_spi_pkg;

    localparam int unsigned SPI_DATA_W = 16;

    // Link runs in SPI mode 0.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus an edge detector on the synced level.
module spi_sync_edge #(
    parameter int unsigned STAGES   = 2,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain and previous-level flop, reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edge detect compares the synced level against its one-cycle-old copy.
    always_comb begin
        level = sync_q[STAGES-1];
        rise  = sync_q[STAGES-1] & ~prev_q;
        fall  = ~sync_q[STAGES-1] & prev_q;
    end

endmodule

// File: rtl/spi_codec_responder.sv
// SPI mode-0 responder: receives one DAC word on mosi and returns one ADC word on miso per frame.
module spi_codec_responder
    import pedal_spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              underrun
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // The sync chains start at idle levels, so a cs_n held low through reset release looks
    // like a fall. Edges are trusted only once every sync and edge flop holds a real sample.
    logic [SYNC_STAGES:0] live_q;
    logic                 settled;
    assign settled = live_q[SYNC_STAGES];

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    // MSB of the loaded word goes straight to miso; only the remaining bits are held here.
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              miso_q, miso_d, oe_q, oe_d;
    logic              tx_ack_q, tx_ack_d, underrun_q, underrun_d;
    logic              rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;

    // State, datapath and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q      <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            tx_ack_q    <= 1'b0;
            underrun_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            live_q      <= {live_q[SYNC_STAGES-1:0], 1'b1};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            tx_ack_q    <= tx_ack_d;
            underrun_q  <= underrun_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame FSM: cs edges frame the transfer, sclk edges move data; cs_rise has priority.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        tx_ack_d    = 1'b0;
        underrun_d  = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall && settled) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    oe_d       = 1'b1;
                    tx_ack_d   = tx_valid;
                    underrun_d = ~tx_valid;
                    tx_shift_d = tx_valid ? tx_data[DATA_W-2:0] : '0;
                    miso_d     = tx_valid & tx_data[DATA_W-1];
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    if (bit_cnt_q == CNT_FULL) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
                    miso_d     = (bit_cnt_q >= CNT_FULL) ? 1'b0 : tx_shift_q[DATA_W-2];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs.
    always_comb begin
        miso      = miso_q;
        miso_oe   = oe_q;
        tx_ack    = tx_ack_q;
        underrun  = underrun_q;
        rx_data   = rx_data_q;
        rx_valid  = rx_valid_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_spi_codec_responder.sv
// Scoreboard bench for spi_codec_responder: an initiator model drives frames and pushes the
// expected miso bits and output pulses; independent monitors pop and compare.
module tb_spi_codec_responder;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n, sclk, cs_n, mosi;
    logic          miso, miso_oe;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ack, rx_valid, frame_err, underrun;

    spi_codec_responder #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } end_exp_t;

    logic     exp_start[$];   // 1 = tx_ack expected, 0 = underrun expected
    end_exp_t exp_end[$];
    logic     exp_miso[$];
    logic [DW-1:0] rx_model;
    logic     chk_miso;
    int       checks = 0;
    int       errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // miso monitor: the initiator samples miso on each sclk rise during a frame.
    always @(posedge sclk) begin
        if (chk_miso && !cs_n) begin
            if (exp_miso.size() == 0) begin
                check("miso_unexpected_bit", 32'd1, 32'd0);
            end else begin
                check("miso_bit", {31'd0, miso}, {31'd0, exp_miso.pop_front()});
                check("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
            end
        end
    end

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (tx_ack || underrun) begin
            if (exp_start.size() == 0) begin
                check("start_pulse_unexpected", {30'd0, tx_ack, underrun}, 32'd0);
            end else begin
                logic e;
                e = exp_start.pop_front();
                check("tx_ack", {31'd0, tx_ack}, {31'd0, e});
                check("underrun", {31'd0, underrun}, {31'd0, ~e});
            end
        end
        if (rx_valid || frame_err) begin
            if (exp_end.size() == 0) begin
                check("end_pulse_unexpected", {30'd0, rx_valid, frame_err}, 32'd0);
            end else begin
                end_exp_t e;
                e = exp_end.pop_front();
                check("rx_valid", {31'd0, rx_valid}, {31'd0, ~e.err});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                check("rx_data", {16'd0, rx_data}, {16'd0, e.data});
            end
        end
    end

    // Expected responses follow directly from the frame description: miso carries the
    // loaded word MSB-first then zeros; only an exact DW-bit frame updates rx_data.
    task automatic push_expect(input int nbits, input logic [DW-1:0] mw, input logic v,
                               input logic [DW-1:0] d);
        logic [DW-1:0] word;
        word = v ? d : '0;
        exp_start.push_back(v);
        for (int i = 0; i < nbits; i++) begin
            exp_miso.push_back(i < DW ? word[DW-1-i] : 1'b0);
        end
        if (nbits == DW) begin
            rx_model = mw;
            exp_end.push_back('{err: 1'b0, data: mw});
        end else begin
            exp_end.push_back('{err: 1'b1, data: rx_model});
        end
    endtask

    // Drive nbits mode-0 sclk periods (clk/8); mosi changes on cs fall and on sclk falls.
    task automatic drive_bits(input int nbits, input logic [DW-1:0] mw);
        logic [DW-1:0] sh;
        sh   = mw;
        mosi = sh[DW-1];
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            sh   = sh << 1;
            mosi = sh[DW-1];
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic run_frame(input int nbits, input logic [DW-1:0] mw, input logic v,
                             input logic [DW-1:0] d, input int gap);
        tx_valid = v;
        tx_data  = d;
        push_expect(nbits, mw, v, d);
        cs_n = 1'b0;
        drive_bits(nbits, mw);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        rx_model = '0;
        chk_miso = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_rx_data", {16'd0, rx_data}, 32'd0);
        check("rst_pulses", {28'd0, tx_ack, rx_valid, frame_err, underrun}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(16, 16'h1234, 1'b1, 16'hA5C3, 8);
        run_frame(16, 16'hFFFF, 1'b0, 16'h5A5A, 8);
        run_frame(12, 16'($urandom), 1'b1, 16'($urandom), 8);
        run_frame(18, 16'($urandom), 1'b1, 16'h8001, 8);

        // Reset after 7 bits, released while cs_n is still low.
        tx_valid = 1'b1;
        tx_data  = 16'h3C96;
        push_expect(7, 16'h0F0F, 1'b1, 16'h3C96);
        void'(exp_end.pop_back());  // the aborted frame produces no end pulse
        cs_n = 1'b0;
        drive_bits(7, 16'h0F0F);
        chk_miso = 1'b0;
        rst_n    = 1'b0;
        rx_model = '0;
        #1;
        check("abort_miso", {31'd0, miso}, 32'd0);
        check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("abort_rx_data", {16'd0, rx_data}, 32'd0);
        check("abort_exp_miso_drained", exp_miso.size(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_bits(5, 16'hFFFF);
        check("post_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_miso = 1'b1;
        run_frame(16, 16'hBEEF, 1'b1, 16'h1357, 8);

        // Back-to-back frames with cs_n high for 4 clk.
        run_frame(16, 16'h0001, 1'b1, 16'h00FF, 4);
        run_frame(16, 16'h8000, 1'b1, 16'hFF00, 8);

        // Randomized frames, with stray sclk activity while cs_n is high.
        for (int n = 0; n < 20; n++) begin
            int nb;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 19)) : DW;
            if ($urandom_range(0, 1) == 1) begin
                sclk = 1'b1;
                repeat (2) @(negedge clk);
                sclk = 1'b0;
                repeat (4) @(negedge clk);
            end
            run_frame(nb, 16'($urandom), 1'($urandom), 16'($urandom), $urandom_range(4, 10));
        end

        repeat (20) @(negedge clk);
        check("exp_start_drained", exp_start.size(), 32'd0);
        check("exp_end_drained", exp_end.size(), 32'd0);
        check("exp_miso_drained", exp_miso.size(), 32'd0);
        check("final_rx_data", {16'd0, rx_data}, {16'd0, rx_model});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
